// File: rtl/scff_chain_ctrl_if.sv
// Signal bundle between the scan-chain sequencer, its management control bits
// and the fabric scan pins (Test_en / sc_head / sc_tail).
interface scff_chain_ctrl_if #(
  parameter int CNT_W = 12
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic             sc_tail;
  logic             test_en;
  logic             sc_head;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [CNT_W-1:0] first_err_idx;

  // master = control/fabric environment, slave = the sequencer itself
  modport master (
    output start, abort, mode, sc_tail,
    input  test_en, sc_head, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    input  start, abort, mode, sc_tail,
    output test_en, sc_head, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/scff_chain_ctrl.sv
// Scan-chain sequencer: shifts an index-defined pattern through the fabric
// chain, flushes with zeros and checks what comes back on sc_tail.
module scff_chain_ctrl #(
  parameter int CHAIN_LEN = 1024,
  parameter int TAIL_LAT  = 0,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             resetb,
  scff_chain_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HEAD_END  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CHK_FIRST = CNT_W'(CHAIN_LEN + TAIL_LAT);
  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(2 * CHAIN_LEN + TAIL_LAT - 1);
  localparam logic [CNT_W-1:0] IDX_NONE  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [1:0]       mode_q, mode_d;
  logic             head_q, head_d;
  logic             ten_q, ten_d;
  logic             pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;

  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] chk_idx;
  logic             in_window;
  logic             exp_bit;
  logic             mismatch;
  logic [15:0]      err_after;
  logic [CNT_W-1:0] fidx_after;

  function automatic logic pattern_bit(input logic [1:0] m, input logic [CNT_W-1:0] idx);
    case (m)
      2'd0:    pattern_bit = (idx == '0);
      2'd1:    pattern_bit = ~idx[0];
      2'd2:    pattern_bit = 1'b1;
      default: pattern_bit = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      mode_q  <= 2'd0;
      head_q  <= 1'b0;
      ten_q   <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 16'd0;
      fidx_q  <= IDX_NONE;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      mode_q  <= mode_d;
      head_q  <= head_d;
      ten_q   <= ten_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
    end
  end

  // Tail compare: the bit leaving the chain in cycle c was driven at index c-CHAIN_LEN-TAIL_LAT.
  // Using !== makes an X/Z tail count as a mismatch rather than poisoning err_count.
  always_comb begin
    cyc_nxt    = cyc_q + 1'b1;
    chk_idx    = cyc_q - CHK_FIRST;
    in_window  = (state_q == S_SHIFT) && (cyc_q >= CHK_FIRST);
    exp_bit    = pattern_bit(mode_q, chk_idx);
    mismatch   = in_window && (bus.sc_tail !== exp_bit);
    err_after  = err_q;
    fidx_after = fidx_q;
    if (mismatch) begin
      if (err_q != 16'hFFFF) begin
        err_after = err_q + 16'd1;
      end
      if (err_q == 16'd0) begin
        fidx_after = chk_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    mode_d  = mode_q;
    head_d  = head_q;
    ten_d   = ten_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fidx_d  = fidx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          mode_d  = bus.mode;
          cyc_d   = '0;
          err_d   = 16'd0;
          pass_d  = 1'b0;
          fidx_d  = IDX_NONE;
          ten_d   = 1'b1;
          head_d  = pattern_bit(bus.mode, '0);
        end
      end

      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          ten_d   = 1'b0;
          head_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          err_d  = err_after;
          fidx_d = fidx_after;
          if (cyc_q == LAST_CYC) begin
            state_d = S_DONE;
            ten_d   = 1'b0;
            head_d  = 1'b0;
            pass_d  = (err_after == 16'd0);
          end else begin
            cyc_d  = cyc_nxt;
            ten_d  = 1'b1;
            head_d = (cyc_nxt < HEAD_END) ? pattern_bit(mode_q, cyc_nxt) : 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        ten_d   = 1'b0;
        head_d  = 1'b0;
      end
    endcase
  end

  assign bus.test_en       = ten_q;
  assign bus.sc_head       = head_q;
  assign bus.busy          = (state_q == S_SHIFT);
  assign bus.done          = (state_q == S_DONE);
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = fidx_q;

endmodule
